// File: rtl/writeback_arbiter_if.sv
// Write-back arbiter bus bundle.
// Carries the producer result handshake (valid/rd/data in, ready out), the
// pipeline hold input, the registered register-file write port, the
// registered grant copy and the combinational back-pressure flag.
//   slave  : arbiter side
//   master : producer / pipeline-controller side
interface writeback_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          stall_i;
  logic                          reg_write_wb_o;
  logic [ADDR_WIDTH-1:0]         reg_rd_wb_o;
  logic [DATA_WIDTH-1:0]         reg_rd_data_wb_o;
  logic [NUM_REQ-1:0]            wb_grant_o;
  logic                          stall_writeback_o;

  modport slave (
    input  req_valid_i, req_rd_i, req_data_i, stall_i,
    output req_ready_o, reg_write_wb_o, reg_rd_wb_o, reg_rd_data_wb_o,
           wb_grant_o, stall_writeback_o
  );

  modport master (
    output req_valid_i, req_rd_i, req_data_i, stall_i,
    input  req_ready_o, reg_write_wb_o, reg_rd_wb_o, reg_rd_data_wb_o,
           wb_grant_o, stall_writeback_o
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter for the single register-file write-back port.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : writeback_arbiter_if.slave
//     req_valid_i/req_rd_i/req_data_i : per-producer result (ALU=0, CSR=1,
//                                       MUL/DIV=2, LSU=3 by default)
//     req_ready_o       : combinational one-hot grant (zero when stalled)
//     stall_i           : pipeline hold, blocks new grants only
//     reg_*_wb_o        : registered write port, one cycle after the grant
//     wb_grant_o        : registered copy of the grant behind the output
//     stall_writeback_o : some valid producer was not granted this cycle
module writeback_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  writeback_arbiter_if.slave  bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_REQ-1:0]    grant;
  } wb_t;

  // Flat slice layout matches a packed array, so lanes view it directly.
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] rd_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;
  assign rd_a   = bus.req_rd_i;
  assign data_a = bus.req_data_i;

  logic [PW-1:0]         ptr, ptr_nxt, gnt_idx;
  logic [PW:0]           idx;
  logic                  found;
  logic [NUM_REQ-1:0]    grant;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  wb_t                   wb_q;

  // Scan from the pointer; the extra idx bit absorbs ptr+i before the wrap.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (!bus.stall_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = {1'b0, ptr} + (PW+1)'(i);
        if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
        if (!found && bus.req_valid_i[idx[PW-1:0]]) begin
          found                = 1'b1;
          grant[idx[PW-1:0]]   = 1'b1;
          gnt_idx              = idx[PW-1:0];
        end
      end
    end
  end

  // One-hot AND-OR mux of the winning lane.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_rd   = sel_rd   | rd_a[k];
        sel_data = sel_data | data_a[k];
      end
    end
  end

  assign ptr_nxt = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  // A grant seen during reset is dropped: the register is cleared instead.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr  <= '0;
      wb_q <= '0;
    end else begin
      // x0 is consumed but never written.
      wb_q.we    <= found && (sel_rd != '0);
      wb_q.grant <= grant;
      if (found) begin
        wb_q.rd   <= sel_rd;
        wb_q.data <= sel_data;
        ptr       <= ptr_nxt;
      end
    end
  end

  assign bus.req_ready_o       = grant;
  assign bus.stall_writeback_o = |(bus.req_valid_i & ~grant);
  assign bus.reg_write_wb_o    = wb_q.we;
  assign bus.reg_rd_wb_o       = wb_q.rd;
  assign bus.reg_rd_data_wb_o  = wb_q.data;
  assign bus.wb_grant_o        = wb_q.grant;
endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  writeback_arbiter #(.NUM_REQ(N), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [N-1:0]         valid = '0;
  logic                 stall = 1'b0;
  logic [N-1:0][4:0]    rd_a  = '0;
  logic [N-1:0][31:0]   data_a = '0;

  assign bus.req_valid_i = valid;
  assign bus.req_rd_i    = rd_a;
  assign bus.req_data_i  = data_a;
  assign bus.stall_i     = stall;

  int total = 0;
  int bad   = 0;

  // Reference state: round-robin pointer and the expected registered port.
  int          m_ptr  = 0;
  logic        e_we   = 1'b0;
  logic [4:0]  e_rd   = '0;
  logic [31:0] e_data = '0;
  logic [N-1:0] e_gnt = '0;
  logic [N-1:0] last_ready;
  logic         last_swb;
  logic [N-1:0] last_model_g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_grant(input int p, input logic [N-1:0] v, input logic s);
    logic [N-1:0] g;
    g = '0;
    if (!s) begin
      for (int i = 0; i < N; i++) begin
        if (g == '0 && v[(p + i) % N]) g[(p + i) % N] = 1'b1;
      end
    end
    return g;
  endfunction

  // Called at a falling edge with inputs applied; returns at the next
  // falling edge after checking the registered port.
  task automatic step();
    logic [N-1:0] g;
    int k;
    #1;
    g = model_grant(m_ptr, valid, stall);
    last_model_g = g;
    last_ready = bus.req_ready_o;
    last_swb   = bus.stall_writeback_o;
    chk("ready", 64'(last_ready), 64'(g));
    chk("stall_wb", 64'(last_swb), 64'(|(valid & ~g)));
    if (rst) begin
      m_ptr = 0; e_we = 1'b0; e_rd = '0; e_data = '0; e_gnt = '0;
    end else begin
      e_gnt = g;
      e_we  = 1'b0;
      if (g != '0) begin
        k = 0;
        for (int j = 0; j < N; j++) if (g[j]) k = j;
        e_we   = (rd_a[k] != 5'd0);
        e_rd   = rd_a[k];
        e_data = data_a[k];
        m_ptr  = (k + 1) % N;
      end
    end
    @(negedge clk);
    chk("reg_write", 64'(bus.reg_write_wb_o), 64'(e_we));
    chk("reg_rd", 64'(bus.reg_rd_wb_o), 64'(e_rd));
    chk("reg_data", 64'(bus.reg_rd_data_wb_o), 64'(e_data));
    chk("wb_grant", 64'(bus.wb_grant_o), 64'(e_gnt));
  endtask

  logic [N-1:0] hold;
  int exp_rd_seq [5] = '{1, 2, 3, 4, 1};
  int exp_rdy_seq[5] = '{1, 2, 4, 8, 1};

  initial begin
    @(negedge clk);
    // 1: reset then a single ALU request
    rst = 1'b1; valid = '0;
    step(); step();
    chk("rst_we", 64'(bus.reg_write_wb_o), 64'd0);
    chk("rst_gnt", 64'(bus.wb_grant_o), 64'd0);
    chk("rst_rd", 64'(bus.reg_rd_wb_o), 64'd0);
    chk("rst_data", 64'(bus.reg_rd_data_wb_o), 64'd0);
    rst = 1'b0;
    valid = 4'b0001; rd_a[0] = 5'd7; data_a[0] = 32'hDEADBEEF;
    step();
    chk("t1_ready", 64'(last_ready), 64'h1);
    chk("t1_we", 64'(bus.reg_write_wb_o), 64'd1);
    chk("t1_rd", 64'(bus.reg_rd_wb_o), 64'd7);
    chk("t1_data", 64'(bus.reg_rd_data_wb_o), 64'hDEADBEEF);
    chk("t1_gnt", 64'(bus.wb_grant_o), 64'h1);
    valid = '0;
    step();
    chk("t1_idle_we", 64'(bus.reg_write_wb_o), 64'd0);
    chk("t1_idle_rd_hold", 64'(bus.reg_rd_wb_o), 64'd7);

    // 2: round-robin from pointer 0 with everyone valid
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < N; k++) begin rd_a[k] = 5'(k + 1); data_a[k] = 32'h100 + k; end
    valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("t2_ready", 64'(last_ready), 64'(exp_rdy_seq[j]));
      chk("t2_swb", 64'(last_swb), 64'd1);
      chk("t2_rd", 64'(bus.reg_rd_wb_o), 64'(exp_rd_seq[j]));
    end

    // 3: move pointer to 3, then requests from 0 and 2
    valid = 4'b0010; step();
    valid = 4'b0100; step();
    valid = 4'b0101; step();
    chk("t3_first", 64'(last_ready), 64'h1);
    valid = 4'b0100; step();
    chk("t3_second", 64'(last_ready), 64'h4);

    // 4: x0 destination from CSR
    valid = 4'b0010; rd_a[1] = 5'd0; data_a[1] = 32'h5;
    step();
    chk("t4_ready", 64'(last_ready), 64'h2);
    chk("t4_we", 64'(bus.reg_write_wb_o), 64'd0);
    chk("t4_gnt", 64'(bus.wb_grant_o), 64'h2);

    // 5: stall with requesters 0 and 3 (pointer is 2)
    valid = 4'b1001; stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t5_ready", 64'(last_ready), 64'd0);
      chk("t5_swb", 64'(last_swb), 64'd1);
      chk("t5_we", 64'(bus.reg_write_wb_o), 64'd0);
    end
    stall = 1'b0;
    step();
    chk("t5_resume", 64'(last_ready), 64'h8);
    valid = 4'b0001; step();
    chk("t5_next", 64'(last_ready), 64'h1);

    // 6: reset in the same cycle as a grant to requester 2 (pointer is 1)
    valid = 4'b0100; rst = 1'b1;
    step();
    chk("t6_ready", 64'(last_ready), 64'h4);
    chk("t6_we", 64'(bus.reg_write_wb_o), 64'd0);
    chk("t6_gnt", 64'(bus.wb_grant_o), 64'd0);
    rst = 1'b0; valid = 4'b0101;
    step();
    chk("t6_ptr0", 64'(last_ready), 64'h1);

    // Random traffic respecting the producer obligations
    valid = '0; hold = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!hold[k] && ($urandom % 3 == 0)) begin
          hold[k]   = 1'b1;
          rd_a[k]   = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
          data_a[k] = $urandom;
        end
      end
      valid = hold;
      stall = ($urandom % 8 == 0);
      rst   = ($urandom % 64 == 0);
      step();
      if (!rst) hold = hold & ~last_model_g;
    end
    rst = 1'b0; stall = 1'b0; valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
